hazard_unit_mc: RTL

HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

---
 rtl/hazard_unit_mc.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and RAW interlocks,
// a multi-cycle E-stage stall FSM, and saturating stall/flush performance counters.
module hazard_unit_mc #(
  parameter int AW     = 5,
  parameter int FWD_EN = 1,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  input  logic [AW-1:0]    Rs1E,
  input  logic [AW-1:0]    Rs2E,
  input  logic [AW-1:0]    RdE,
  input  logic [AW-1:0]    RdM,
  input  logic [AW-1:0]    RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             McStartE,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             McBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {IDLE, BUSY} mcState_t;

  localparam logic [3:0]       MC_LOAD = (MC_LAT >= 2) ? 4'(MC_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mcState_t   state;
  logic [3:0] mcCnt;
  logic       mcStall;
  logic       lwStall;
  logic       rawStall;
  logic       rs1Raw;
  logic       rs2Raw;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (FWD_EN != 0) begin
      if (Rs1E != '0 && RegWriteM && Rs1E == RdM)      ForwardAE = 2'b10;
      else if (Rs1E != '0 && RegWriteW && Rs1E == RdW) ForwardAE = 2'b01;
      if (Rs2E != '0 && RegWriteM && Rs2E == RdM)      ForwardBE = 2'b10;
      else if (Rs2E != '0 && RegWriteW && Rs2E == RdW) ForwardBE = 2'b01;
    end
  end

  // Without forwarding, any in-flight producer in E or M must drain; W writes before D reads.
  always_comb begin
    lwStall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    rs1Raw   = (Rs1D != '0) && ((RegWriteE && Rs1D == RdE) || (RegWriteM && Rs1D == RdM));
    rs2Raw   = (Rs2D != '0) && ((RegWriteE && Rs2D == RdE) || (RegWriteM && Rs2D == RdM));
    rawStall = (FWD_EN == 0) && (rs1Raw || rs2Raw);
    mcStall  = (state == BUSY) || (McStartE && (MC_LAT >= 2));
  end

  assign StallF = mcStall || lwStall || rawStall;
  assign StallD = StallF;
  assign StallE = mcStall;
  assign FlushM = mcStall;
  assign FlushE = !mcStall && (lwStall || rawStall || PCSrcE);
  assign FlushD = !mcStall && PCSrcE;
  assign McBusy = (state == BUSY);

  // mcCnt holds the BUSY cycles still to go, counting the current one, so the start
  // cycle plus MC_LAT-2 BUSY cycles gives MC_LAT-1 stalled cycles in total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (McStartE && (MC_LAT >= 3)) begin
            state <= BUSY;
            mcCnt <= MC_LOAD;
          end
        end
        BUSY: begin
          if (mcCnt <= 4'd1) begin
            state <= IDLE;
            mcCnt <= '0;
          end else begin
            mcCnt <= mcCnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          mcCnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && StallCount != CNT_MAX) StallCount <= StallCount + CNT_W'(1);
      if (FlushD && FlushCount != CNT_MAX) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule
